mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters: WORD_WIDTH, default 8, data word width; ADDR_WIDTH, default 8, word-address width; LATENCY, default 2, wait cycles per access (legal range 1..15); PROT_LIMIT, default 16, first writable address when protection is compiled in.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 addr  input  ADDR_WIDTH  word address from MAR, sampled when a request is accepted.
REQ-005 mem_read  input  1  read request from the MDR side; held high until ready.
REQ-006 mem_write  input  1  write request; the MDR drives mem while this is high.
REQ-007 mem  inout  WORD_WIDTH  shared data bus; driven by mem_ctrl only as stated in REQ-015, else high-Z.
REQ-008 busy  output  1  high while an access is in progress (WAIT or DONE).
REQ-009 ready  output  1  one-cycle pulse marking access completion.
REQ-010 fault  output  1  one-cycle pulse on a rejected access.

Function
REQ-011 Storage: 2**ADDR_WIDTH words of WORD_WIDTH bits, one access in flight at a time.
REQ-012 FSM states: IDLE, WAIT, DONE. IDLE->WAIT on an accepted request; WAIT->DONE once the wait counter reaches 0; DONE->IDLE unconditionally.
REQ-013 Accept: in IDLE at posedge with mem_read or mem_write high; latch addr and op; for a write, latch mem into the write buffer at this same edge; load the wait counter with LATENCY-1.
REQ-014 Both mem_read and mem_write high in IDLE: read is accepted, write is dropped, and fault pulses in the following cycle.
REQ-015 Read: array word is registered on the WAIT->DONE edge; mem is driven with it only during DONE with op=read, else 'bZ.
REQ-016 Write: buffer is committed to the array on the WAIT->DONE edge; mem is never driven during a write.
REQ-017 Latency: request sampled at edge E0; ready=1 in the cycle after edge E(LATENCY); the requester's final sample at the end of DONE returns the correct data.
REQ-018 busy=1 throughout WAIT and DONE; requests seen while busy are ignored and not queued.
REQ-019 Back-to-back: a request held high through DONE is accepted at the DONE->IDLE edge+1, so at most one access completes every LATENCY+2 cycles.
REQ-020 Requester dropping mem_read/mem_write mid-access does not abort it; the access completes normally.
REQ-021 Address wraps modulo 2**ADDR_WIDTH; no out-of-range condition exists.

Reset
REQ-022 rst at posedge: state=IDLE, counter=0, busy=0, ready=0, fault=0, mem released to 'bZ, and any in-flight write discarded.
REQ-023 rst does not clear array contents; power-up initial contents are all zero.
REQ-024 rst takes priority over every other event, including the WAIT->DONE commit edge.

Configuration
REQ-025 With MEM_PROTECT_EN defined: an accepted write to addr < PROT_LIMIT is not committed, fault pulses in the DONE cycle, and ready still pulses.
REQ-026 Without MEM_PROTECT_EN: all writes commit and fault is driven only by REQ-014.

Verification
REQ-027 rst, then write addr=0x20 data=0xA5 (LATENCY=2) -> busy for 3 cycles, ready in cycle 3, array[0x20]=0xA5.
REQ-028 Read addr=0x20 after REQ-027 -> mem='bZ until DONE, mem=0xA5 during DONE with ready=1, then 'bZ.
REQ-029 mem_read and mem_write both high, addr=0x30 -> read of 0x30 is performed, fault=1 for one cycle, array[0x30] unchanged.
REQ-030 rst asserted during WAIT of a write of 0x5A to 0x40 -> IDLE next cycle, array[0x40] keeps its old value, no ready pulse.
REQ-031 MEM_PROTECT_EN defined, write 0xFF to addr=0x05 -> ready and fault pulse together, array[0x05] unchanged; write to 0x10 commits.
REQ-032 Request held continuously for 3 reads at 0x00/0x01/0x02 -> ready pulses spaced exactly 4 cycles apart, with correct data each time.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port word memory behind a fixed-latency request/ready handshake
// with a shared tristate data bus.
// Optional build macro: MEM_PROTECT_EN. When it is defined, writes below PROT_LIMIT
// are rejected. They still complete with ready, and fault is raised in the DONE cycle.
module mem_ctrl #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned PROT_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  mem_read,
  input  logic                  mem_write,
  inout  wire  [WORD_WIDTH-1:0] mem,
  output logic                  busy,
  output logic                  ready,
  output logic                  fault
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    op_wr;
  logic [WORD_WIDTH-1:0]   wbuf;
  logic [WORD_WIDTH-1:0]   rdata;
  logic                    drive;
  logic                    accept;
  logic                    commit;
  logic                    fault_next;
  logic                    prot_hit;
  logic [WORD_WIDTH-1:0]   array_q [DEPTH];

`ifdef MEM_PROTECT_EN
  // A latched write address in the protected low region blocks the commit.
  assign prot_hit = (32'(addr_q) < PROT_LIMIT);
`else
  assign prot_hit = 1'b0;
`endif

  // The bus is driven only while a completed read is being presented.
  assign mem = drive ? rdata : {WORD_WIDTH{1'bz}};

  // Compute the next state, the wait counter, and the fault conditions.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    fault_next = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept     = 1'b1;
          state_next = WAIT;
          cnt_next   = CNT_W'(LATENCY - 1);
          fault_next = mem_read && mem_write;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = DONE;
          commit     = 1'b1;
          fault_next = op_wr && prot_hit;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, request capture, and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      op_wr  <= 1'b0;
      wbuf   <= '0;
      drive  <= 1'b0;
      busy   <= 1'b0;
      ready  <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= (state_next != IDLE);
      ready <= (state_next == DONE);
      fault <= fault_next;
      drive <= (state_next == DONE) && !op_wr;
      if (accept) begin
        addr_q <= addr;
        // When both requests are high, the read wins and the write is dropped.
        op_wr  <= mem_write && !mem_read;
        if (mem_write && !mem_read) begin
          wbuf <= mem;
        end
      end
    end
  end

  // Array port: commit the write or capture read data on the WAIT->DONE edge. Reset does not clear the contents.
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      if (op_wr) begin
        if (!prot_hit) begin
          array_q[addr_q] <= wbuf;
        end
      end else begin
        rdata <= array_q[addr_q];
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard-driven bench for mem_ctrl.
// A pull-up on the data bus makes a released bus read back as all ones.
module tb_mem_ctrl;

  localparam int unsigned WW   = 8;
  localparam int unsigned AW   = 8;
  localparam int unsigned LAT  = 2;
  localparam int unsigned PLIM = 16;
  localparam logic [WW-1:0] RELEASED = {WW{1'b1}};

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          mem_read;
  logic          mem_write;
  logic          tb_drive;
  logic [WW-1:0] tb_data;
  wire  [WW-1:0] mem;
  logic          busy;
  logic          ready;
  logic          fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WW-1:0] data;
    logic          flt_early;
    logic          flt_done;
  } exp_t;

  exp_t          sbq[$];
  logic [WW-1:0] model [2**AW];

  mem_ctrl #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LATENCY(LAT), .PROT_LIMIT(PLIM)) dut (
    .clk(clk), .rst(rst), .addr(addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem(mem), .busy(busy), .ready(ready), .fault(fault)
  );

  always #5 clk = ~clk;

  assign mem = tb_drive ? tb_data : {WW{1'bz}};

  for (genvar i = 0; i < WW; i++) begin : g_pu
    pullup pu (mem[i]);
  end

  function automatic logic prot(input logic [AW-1:0] a);
`ifdef MEM_PROTECT_EN
    return 32'(a) < PLIM;
`else
    return 1'b0;
`endif
  endfunction

  // Drive a request and push its expected outcome onto the scoreboard.
  task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [WW-1:0] d);
    exp_t e;
    addr      = a;
    mem_read  = rd;
    mem_write = wr;
    tb_drive  = wr;
    tb_data   = d;
    e.flt_early = rd && wr;
    e.flt_done  = 1'b0;
    if (rd) begin
      e.data = model[a];
    end else begin
      e.data     = RELEASED;
      e.flt_done = prot(a);
      if (!prot(a)) model[a] = d;
    end
    sbq.push_back(e);
  endtask

  // Run one access with a one-cycle request, and collect what the DUT shows in each cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [WW-1:0] d, output logic [WW-1:0] got,
                            output int rdy_cyc, output int busy_cnt,
                            output logic f_early, output logic f_done, output logic bad);
    @(negedge clk);
    issue(rd, wr, a, d);
    got = '0; rdy_cyc = 0; busy_cnt = 0; f_early = 0; f_done = 0; bad = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      mem_read = 0; mem_write = 0; tb_drive = 0;
      #1;
      if (busy) busy_cnt++;
      if (fault && c == 1) f_early = 1;
      else if (fault && ready) f_done = 1;
      else if (fault) bad = 1;
      if (ready) begin
        rdy_cyc = c;
        got = mem;
      end else if (mem !== RELEASED) begin
        bad = 1;
      end
      if (rdy_cyc != 0 && c == rdy_cyc + 1) break;
    end
  endtask

  task automatic test_reset();
    rst = 1; mem_read = 0; mem_write = 0; addr = '0; tb_drive = 0; tb_data = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (mem !== RELEASED) begin failures++; $display("FAIL reset_mem got=%h exp=%h", mem, RELEASED); end
    rst = 0;
  endtask

  task automatic test_write();
    logic [WW-1:0] got; int rc, bc; logic fe, fd, bad; exp_t e;
    run_access(0, 1, 8'h20, 8'hA5, got, rc, bc, fe, fd, bad);
    e = sbq.pop_front();
    checks++; if (rc !== LAT + 1) begin failures++; $display("FAIL write_ready_cycle got=%0d exp=%0d", rc, LAT + 1); end
    checks++; if (bc !== LAT + 1) begin failures++; $display("FAIL write_busy_cycles got=%0d exp=%0d", bc, LAT + 1); end
    checks++; if (got !== e.data) begin failures++; $display("FAIL write_bus_in_done got=%h exp=%h", got, e.data); end
    checks++; if ({fe, fd, bad} !== {e.flt_early, e.flt_done, 1'b0}) begin
      failures++; $display("FAIL write_flags got=%b%b%b exp=%b%b0", fe, fd, bad, e.flt_early, e.flt_done);
    end
  endtask

  task automatic test_read();
    logic [WW-1:0] got; int rc, bc; logic fe, fd, bad; exp_t e;
    run_access(1, 0, 8'h20, 8'h00, got, rc, bc, fe, fd, bad);
    e = sbq.pop_front();
    checks++; if (got !== e.data) begin failures++; $display("FAIL read_data got=%h exp=%h", got, e.data); end
    checks++; if (rc !== LAT + 1) begin failures++; $display("FAIL read_ready_cycle got=%0d exp=%0d", rc, LAT + 1); end
    checks++; if (bc !== LAT + 1) begin failures++; $display("FAIL read_busy_cycles got=%0d exp=%0d", bc, LAT + 1); end
    checks++; if ({fe, fd, bad} !== 3'b000) begin failures++; $display("FAIL read_flags got=%b%b%b exp=000", fe, fd, bad); end
  endtask

  task automatic test_dual();
    logic [WW-1:0] got; int rc, bc; logic fe, fd, bad; exp_t e;
    run_access(0, 1, 8'h30, 8'h3C, got, rc, bc, fe, fd, bad);
    e = sbq.pop_front();
    checks++; if (rc !== LAT + 1) begin failures++; $display("FAIL dual_preload_ready got=%0d exp=%0d", rc, LAT + 1); end
    run_access(1, 1, 8'h30, 8'h77, got, rc, bc, fe, fd, bad);
    e = sbq.pop_front();
    checks++; if (got !== e.data) begin failures++; $display("FAIL dual_read_data got=%h exp=%h", got, e.data); end
    checks++; if ({fe, fd, bad} !== {e.flt_early, 2'b00}) begin
      failures++; $display("FAIL dual_fault got=%b%b%b exp=%b00", fe, fd, bad, e.flt_early);
    end
    run_access(1, 0, 8'h30, 8'h00, got, rc, bc, fe, fd, bad);
    e = sbq.pop_front();
    checks++; if (got !== e.data) begin failures++; $display("FAIL dual_array_kept got=%h exp=%h", got, e.data); end
  endtask

  task automatic test_rst_mid();
    logic [WW-1:0] got; int rc, bc; logic fe, fd, bad; exp_t e; int rdy_seen;
    run_access(0, 1, 8'h40, 8'h11, got, rc, bc, fe, fd, bad);
    e = sbq.pop_front();
    checks++; if (rc !== LAT + 1) begin failures++; $display("FAIL rstmid_preload_ready got=%0d exp=%0d", rc, LAT + 1); end
    // The write is abandoned, so the model is not updated.
    @(negedge clk);
    addr = 8'h40; mem_write = 1; tb_drive = 1; tb_data = 8'h5A;
    @(negedge clk);
    mem_write = 0; tb_drive = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    checks++; if ({busy, ready, fault} !== 3'b000) begin
      failures++; $display("FAIL rstmid_outputs got=%b%b%b exp=000", busy, ready, fault);
    end
    rst = 0;
    rdy_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (ready) rdy_seen++;
    end
    checks++; if (rdy_seen !== 0) begin failures++; $display("FAIL rstmid_no_ready got=%0d exp=0", rdy_seen); end
    run_access(1, 0, 8'h40, 8'h00, got, rc, bc, fe, fd, bad);
    e = sbq.pop_front();
    checks++; if (got !== e.data) begin failures++; $display("FAIL rstmid_array_kept got=%h exp=%h", got, e.data); end
  endtask

`ifdef MEM_PROTECT_EN
  task automatic test_protect();
    logic [WW-1:0] got; int rc, bc; logic fe, fd, bad; exp_t e;
    run_access(0, 1, 8'h05, 8'hFF, got, rc, bc, fe, fd, bad);
    e = sbq.pop_front();
    checks++; if ({rc == LAT + 1, fd} !== {1'b1, e.flt_done}) begin
      failures++; $display("FAIL prot_low_ready_fault got=%0d/%b exp=%0d/%b", rc, fd, LAT + 1, e.flt_done);
    end
    run_access(1, 0, 8'h05, 8'h00, got, rc, bc, fe, fd, bad);
    e = sbq.pop_front();
    checks++; if (got !== e.data) begin failures++; $display("FAIL prot_low_kept got=%h exp=%h", got, e.data); end
    run_access(0, 1, 8'h10, 8'h4B, got, rc, bc, fe, fd, bad);
    e = sbq.pop_front();
    run_access(1, 0, 8'h10, 8'h00, got, rc, bc, fe, fd, bad);
    e = sbq.pop_front();
    checks++; if (got !== e.data) begin failures++; $display("FAIL prot_edge_commit got=%h exp=%h", got, e.data); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [WW-1:0] got; int rc, bc; logic fe, fd, bad; exp_t e;
    int n; int cyc [3];
    for (int i = 0; i < 3; i++) begin
      run_access(0, 1, AW'(i), WW'(8'h61 + i), got, rc, bc, fe, fd, bad);
      e = sbq.pop_front();
    end
    @(negedge clk);
    issue(1, 0, 8'h00, 8'h00);
    issue(1, 0, 8'h01, 8'h00);
    issue(1, 0, 8'h02, 8'h00);
    addr = 8'h00; mem_read = 1;
    n = 0;
    for (int c = 1; c <= 40 && n < 3; c++) begin
      @(negedge clk); #1;
      if (ready) begin
        cyc[n] = c;
        e = sbq.pop_front();
        checks++; if (mem !== e.data) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", n, mem, e.data); end
        n++;
        addr = AW'(n);
        if (n == 3) mem_read = 0;
      end
    end
    mem_read = 0;
    checks++; if (n !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n); end
    if (n == 3) begin
      checks++; if (cyc[1] - cyc[0] !== LAT + 2) begin failures++; $display("FAIL b2b_gap01 got=%0d exp=%0d", cyc[1] - cyc[0], LAT + 2); end
      checks++; if (cyc[2] - cyc[1] !== LAT + 2) begin failures++; $display("FAIL b2b_gap12 got=%0d exp=%0d", cyc[2] - cyc[1], LAT + 2); end
    end
    repeat (LAT + 3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
    test_reset();
    test_write();
    test_read();
    test_dual();
    test_rst_mid();
`ifdef MEM_PROTECT_EN
    test_protect();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
